// File: rtl/clk_div_ctrl_pkg.sv
// rtl/clk_div_ctrl_pkg.sv - shared types and constants for the clock divider controller
package clk_div_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2,
        STOP = 2'd3
    } state_t;

    localparam int DEF_HALF_RST = 2;
    localparam int PERIOD_W     = 16;

endpackage

// File: rtl/clk_div_ctrl_if.sv
// rtl/clk_div_ctrl_if.sv - half-period configuration handshake channel
interface clk_div_ctrl_if #(
    parameter int CNT_W = 8
);
    logic             cfg_valid;
    logic [CNT_W-1:0] cfg_half;
    logic             cfg_ready;

    modport master (
        output cfg_valid,
        output cfg_half,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_half,
        output cfg_ready
    );

endinterface

// File: rtl/clk_div_core.sv
// rtl/clk_div_core.sv - half-period counter, divided clock and edge tick registers
module clk_div_core #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [CNT_W-1:0] half,
    input  logic             restart,
    output logic             clk_out,
    output logic             tick_rise,
    output logic             tick_fall,
    output logic             wrap,
    output logic             toggle_low
);

    logic [CNT_W-1:0] cnt;

    // Wrap at half-1 so the counter never needs more than CNT_W bits.
    assign wrap       = (cnt == half - CNT_W'(1));
    assign toggle_low = wrap && clk_out;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt       <= '0;
            clk_out   <= 1'b0;
            tick_rise <= 1'b0;
            tick_fall <= 1'b0;
        end else if (!run) begin
            cnt       <= '0;
            clk_out   <= 1'b0;
            tick_rise <= 1'b0;
            tick_fall <= 1'b0;
        end else begin
            tick_rise <= wrap && !clk_out;
            tick_fall <= wrap && clk_out;
            if (wrap)
                clk_out <= !clk_out;
            if (wrap || restart)
                cnt <= '0;
            else
                cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/clk_div_ctrl.sv
// rtl/clk_div_ctrl.sv - programmable glitch-free clock divider controller
// Optional 16-bit period counter output enabled by CLK_DIV_CTRL_STATS_EN.
module clk_div_ctrl
    import clk_div_ctrl_pkg::*;
#(
    parameter int CNT_W    = 8,
    parameter int DEF_HALF = DEF_HALF_RST
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    clk_div_ctrl_if.slave       cfg,
    output logic                cfg_err,
    output logic [CNT_W-1:0]    cur_half,
    output logic                clk_out,
    output logic                tick_rise,
    output logic                tick_fall,
`ifdef CLK_DIV_CTRL_STATS_EN
    output logic [PERIOD_W-1:0] period_cnt,
`endif
    output logic                busy
);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] pend_half;
    logic             pend_valid;
    logic             accept, cfg_zero;
    logic             run, restart, wrap, toggle_low;
    logic             load_cfg, store_pend, apply_pend;

    assign cfg.cfg_ready = (state == IDLE) || (state == RUN);
    assign accept        = cfg.cfg_valid && cfg.cfg_ready;
    assign cfg_zero      = (cfg.cfg_half == '0);
    assign busy          = (state != IDLE);
    assign restart       = apply_pend;

    always_comb begin
        state_nxt  = state;
        run        = (state != IDLE);
        load_cfg   = 1'b0;
        store_pend = 1'b0;
        apply_pend = 1'b0;
        case (state)
            IDLE: begin
                load_cfg = accept && !cfg_zero;
                if (en)
                    state_nxt = RUN;
            end
            RUN: begin
                if (accept && !cfg_zero) begin
                    store_pend = 1'b1;
                    state_nxt  = en ? PEND : STOP;
                end else if (!en) begin
                    state_nxt = STOP;
                end
            end
            PEND: begin
                if (toggle_low) begin
                    apply_pend = 1'b1;
                    state_nxt  = en ? RUN : STOP;
                end else if (!en) begin
                    state_nxt = STOP;
                end
            end
            STOP: begin
                if (en) begin
                    if (pend_valid && toggle_low) begin
                        apply_pend = 1'b1;
                        state_nxt  = RUN;
                    end else begin
                        state_nxt = pend_valid ? PEND : RUN;
                    end
                end else if (toggle_low || (wrap && !clk_out)) begin
                    // Ending on a low-phase wrap must not let the core toggle high.
                    apply_pend = pend_valid;
                    run        = clk_out;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cur_half   <= CNT_W'(DEF_HALF);
            pend_half  <= '0;
            pend_valid <= 1'b0;
            cfg_err    <= 1'b0;
        end else begin
            state   <= state_nxt;
            cfg_err <= accept && cfg_zero;
            if (load_cfg)
                cur_half <= cfg.cfg_half;
            else if (apply_pend)
                cur_half <= pend_half;
            if (store_pend) begin
                pend_half  <= cfg.cfg_half;
                pend_valid <= 1'b1;
            end else if (apply_pend) begin
                pend_valid <= 1'b0;
            end
        end
    end

`ifdef CLK_DIV_CTRL_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            period_cnt <= '0;
        else if (load_cfg || apply_pend)
            period_cnt <= '0;
        else if (tick_rise)
            period_cnt <= period_cnt + PERIOD_W'(1);
    end
`endif

    clk_div_core #(
        .CNT_W (CNT_W)
    ) u_core (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .half       (cur_half),
        .restart    (restart),
        .clk_out    (clk_out),
        .tick_rise  (tick_rise),
        .tick_fall  (tick_fall),
        .wrap       (wrap),
        .toggle_low (toggle_low)
    );

endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb/tb_clk_div_ctrl.sv - directed self-checking bench for clk_div_ctrl
module tb_clk_div_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       cfg_err;
    logic [7:0] cur_half;
    logic       clk_out;
    logic       tick_rise;
    logic       tick_fall;
    logic       busy;
`ifdef CLK_DIV_CTRL_STATS_EN
    logic [15:0] period_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    clk_div_ctrl_if #(.CNT_W(8)) cfg_bus ();

    clk_div_ctrl #(.CNT_W(8), .DEF_HALF(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .cfg        (cfg_bus),
        .cfg_err    (cfg_err),
        .cur_half   (cur_half),
        .clk_out    (clk_out),
        .tick_rise  (tick_rise),
        .tick_fall  (tick_fall),
`ifdef CLK_DIV_CTRL_STATS_EN
        .period_cnt (period_cnt),
`endif
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // en was just raised in IDLE: the enabling edge plus half-1 more cycles stay low.
    task automatic start_run(input string tag, input int half);
        step();
        check({tag, "_busy"}, busy, 1);
        check({tag, "_lo0"}, clk_out, 0);
        for (int i = 1; i < half; i++) begin
            step();
            check({tag, "_lo"}, clk_out, 0);
        end
    endtask

    // Next sample is the first cycle of a phase whose level is first_val.
    task automatic expect_wave(input string tag, input int half, input logic first_val, input int phases);
        logic v;
        v = first_val;
        for (int p = 0; p < phases; p++) begin
            for (int c = 0; c < half; c++) begin
                step();
                check({tag, "_clk"}, clk_out, v);
                check({tag, "_rise"}, tick_rise, (c == 0) && v);
                check({tag, "_fall"}, tick_fall, (c == 0) && !v);
            end
            v = !v;
        end
    endtask

    initial begin
        reset = 1'b0;
        en = 1'b0;
        cfg_bus.cfg_valid = 1'b0;
        cfg_bus.cfg_half = 8'd0;
        repeat (2) step();
        check("rst_clk_out", clk_out, 0);
        check("rst_cur_half", cur_half, 2);
        check("rst_cfg_err", cfg_err, 0);
        check("rst_tick_rise", tick_rise, 0);
        check("rst_tick_fall", tick_fall, 0);
        check("rst_busy", busy, 0);
        check("rst_cfg_ready", cfg_bus.cfg_ready, 1);
        reset = 1'b1;
        step();
        check("idle_busy", busy, 0);

        // Default divide-by-4
        en = 1'b1;
        start_run("run2", 2);
        expect_wave("run2", 2, 1'b1, 4);

        // Reconfigure to 5 while running; accepted on a rising toggle
        cfg_bus.cfg_valid = 1'b1;
        cfg_bus.cfg_half = 8'd5;
        step();
        cfg_bus.cfg_valid = 1'b0;
        check("cfg5_ready", cfg_bus.cfg_ready, 0);
        check("cfg5_hi", clk_out, 1);
        check("cfg5_busy", busy, 1);
        step();
        check("cfg5_old_half", cur_half, 2);
        check("cfg5_hi2", clk_out, 1);
        expect_wave("half5", 5, 1'b0, 2);
        check("cfg5_cur", cur_half, 5);
        check("cfg5_ready_back", cfg_bus.cfg_ready, 1);

        // Illegal zero config
        cfg_bus.cfg_valid = 1'b1;
        cfg_bus.cfg_half = 8'd0;
        step();
        cfg_bus.cfg_valid = 1'b0;
        check("err_pulse", cfg_err, 1);
        check("err_cur_half", cur_half, 5);
        check("err_ready", cfg_bus.cfg_ready, 1);
        check("err_clk_lo", clk_out, 0);
        step();
        check("err_one_cycle", cfg_err, 0);
        check("err_busy", busy, 1);
        repeat (3) step();
        expect_wave("after_err", 5, 1'b1, 2);

        // Switch to 3, then stop mid-high-phase
        cfg_bus.cfg_valid = 1'b1;
        cfg_bus.cfg_half = 8'd3;
        step();
        cfg_bus.cfg_valid = 1'b0;
        check("cfg3_ready", cfg_bus.cfg_ready, 0);
        repeat (4) step();
        expect_wave("half3", 3, 1'b0, 3);
        check("cfg3_cur", cur_half, 3);
        step();
        check("stop_hi_start", clk_out, 1);
        check("stop_hi_tick", tick_rise, 1);
        en = 1'b0;
        step();
        check("stop_hi2", clk_out, 1);
        check("stop_busy", busy, 1);
        step();
        check("stop_hi3", clk_out, 1);
        step();
        check("stop_lo", clk_out, 0);
        check("stop_idle", busy, 0);
        check("stop_fall", tick_fall, 1);
        for (int i = 0; i < 5; i++) begin
            step();
            check("stop_hold_lo", clk_out, 0);
            check("stop_no_rise", tick_rise, 0);
        end

        // Divide-by-2, configured while idle
        cfg_bus.cfg_valid = 1'b1;
        cfg_bus.cfg_half = 8'd1;
        step();
        cfg_bus.cfg_valid = 1'b0;
        check("idle_cfg1", cur_half, 1);
        check("idle_cfg1_busy", busy, 0);
        en = 1'b1;
        start_run("run1", 1);
        expect_wave("run1", 1, 1'b1, 4);
        en = 1'b0;
        step();
        check("stop1_hi", clk_out, 1);
        check("stop1_busy", busy, 1);
        step();
        check("stop1_lo", clk_out, 0);
        check("stop1_idle", busy, 0);

        // Reset while a config is pending
        en = 1'b1;
        step();
        cfg_bus.cfg_valid = 1'b1;
        cfg_bus.cfg_half = 8'd7;
        step();
        cfg_bus.cfg_valid = 1'b0;
        check("pend_busy", busy, 1);
        check("pend_ready", cfg_bus.cfg_ready, 0);
        reset = 1'b0;
        #1;
        check("arst_clk_out", clk_out, 0);
        check("arst_cur_half", cur_half, 2);
        check("arst_busy", busy, 0);
        check("arst_ready", cfg_bus.cfg_ready, 1);
        check("arst_rise", tick_rise, 0);
        check("arst_fall", tick_fall, 0);
        check("arst_err", cfg_err, 0);
        repeat (2) step();
        reset = 1'b1;
        start_run("rerun2", 2);
        expect_wave("rerun2", 2, 1'b1, 20);
`ifdef CLK_DIV_CTRL_STATS_EN
        check("stats_10", period_cnt, 10);
`endif

        // Config pending when en drops: applied as the controller idles
        cfg_bus.cfg_valid = 1'b1;
        cfg_bus.cfg_half = 8'd3;
        step();
        cfg_bus.cfg_valid = 1'b0;
        check("pstop_hi", clk_out, 1);
        check("pstop_ready", cfg_bus.cfg_ready, 0);
        en = 1'b0;
        step();
        check("pstop_hi2", clk_out, 1);
        check("pstop_old_half", cur_half, 2);
        step();
        check("pstop_lo", clk_out, 0);
        check("pstop_idle", busy, 0);
        check("pstop_applied", cur_half, 3);
`ifdef CLK_DIV_CTRL_STATS_EN
        check("stats_clr", period_cnt, 0);
`endif
        en = 1'b1;
        start_run("run3", 3);
        expect_wave("run3", 3, 1'b1, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
